// File: rtl/regfile.sv
// ============================================================================
// Module   : regfile
// Purpose  : 31x WIDTH register file (r0 hardwired to zero) with two
//            combinational read ports, a debug port and a write counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module regfile #(
  parameter int WIDTH  = 32,
  parameter bit BYPASS = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rna,
  input  logic [4:0]       rnb,
  input  logic [4:0]       wn,
  input  logic [WIDTH-1:0] d,
  input  logic             we,
  output logic [WIDTH-1:0] qa,
  output logic [WIDTH-1:0] qb,
  input  logic [4:0]       dbg_rn,
  output logic [WIDTH-1:0] dbg_q,
  output logic [31:0]      wcount
);

  logic [WIDTH-1:0] regs_q [1:31];
  logic [31:0]      wcount_q;
  logic [31:0]      wcount_d;
  logic             wr_en;

  // A write to r0 is silently discarded and never counted.
  assign wr_en    = we && !reset && (wn != 5'd0);
  assign wcount_d = wcount_q + 32'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= '0;
      end
      wcount_q <= '0;
    end else if (wr_en) begin
      regs_q[wn] <= d;
      wcount_q   <= wcount_d;
    end
  end

  always_comb begin
    qa    = '0;
    qb    = '0;
    dbg_q = '0;
    if (rna != 5'd0) begin
      qa = (BYPASS && wr_en && (wn == rna)) ? d : regs_q[rna];
    end
    if (rnb != 5'd0) begin
      qb = (BYPASS && wr_en && (wn == rnb)) ? d : regs_q[rnb];
    end
    // The debug port always shows committed state.
    if (dbg_rn != 5'd0) begin
      dbg_q = regs_q[dbg_rn];
    end
  end

  assign wcount = wcount_q;

endmodule

`default_nettype wire
